rca_pipe_addsub: RTL and testbench

//   Parametrised, pipelined ripple-carry adder/subtractor. Successor to the 4-bit combinational RCA.

---
 rtl/rca_pipe_addsub_pkg.sv | 23 ++
 rtl/rca_pipe_addsub_chunk.sv | 30 +++
 rtl/rca_pipe_addsub.sv | 134 +++++++++++++
 tb/tb_rca_pipe_addsub.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rca_pipe_addsub_pkg.sv
// Shared helpers for the pipelined ripple-carry adder/subtractor:
// chunk sizing, configuration sanity check and the per-stage control record.
package rca_pkg;

   // Bits rippled by each pipeline stage.
   function automatic int rca_chunk_w(input int width, input int stages);
      return width / stages;
   endfunction

   // Operands must split into equal, non-empty chunks.
   function automatic bit rca_cfg_ok(input int width, input int stages);
      return (stages > 0) && (width >= stages) && ((width % stages) == 0);
   endfunction

   // Control part of a stage record. c_msb is the carry into the current
   // MSB; after the last stage it is the carry into bit WIDTH-1 used for ovf.
   typedef struct packed {
      logic valid;
      logic carry;
      logic c_msb;
   } rca_ctrl_t;

endpackage

// File: rtl/rca_pipe_addsub_chunk.sv
// Combinational CHUNK-bit ripple of full adders. Besides the carry out it
// exposes the carry into its top bit so the final stage can form signed
// overflow.
module rca_chunk #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] sum,
   output logic             cout,
   output logic             c_msb_in
);

   logic [CHUNK:0] w_c;

   assign w_c[0] = cin;

   genvar gi;
   generate
      for (gi = 0; gi < CHUNK; gi++) begin : g_fa
         assign sum[gi]    = a[gi] ^ b[gi] ^ w_c[gi];
         assign w_c[gi+1]  = (a[gi] & b[gi]) | (w_c[gi] & (a[gi] ^ b[gi]));
      end
   endgenerate

   assign cout     = w_c[CHUNK];
   assign c_msb_in = w_c[CHUNK-1];

endmodule

// File: rtl/rca_pipe_addsub.sv
// Pipelined ripple-carry adder/subtractor. One CHUNK-bit slice ripples per
// stage; the carry, the finished low sum bits and the still-pending high
// operand bits travel down the pipe. The last stage register is the output
// register. A single global stall freezes every stage, bubbles included.
module rca_pipe_addsub
   import rca_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int CHUNK = rca_chunk_w(WIDTH, STAGES);

   generate
      if (!rca_cfg_ok(WIDTH, STAGES)) begin : g_cfg_err
         $error("rca_pipe_addsub: WIDTH must be a non-zero multiple of STAGES");
      end
   endgenerate

   // Stage record: pending operand bits are kept right-aligned so every
   // stage reads its slice from bit 0.
   typedef struct packed {
      rca_ctrl_t        ctrl;
      logic [WIDTH-1:0] sum_lo;
      logic [WIDTH-1:0] a_hi;
      logic [WIDTH-1:0] b_hi;
   } stage_t;

   // w_link[s] feeds stage s; w_link[STAGES] is the output register.
   stage_t           w_link [STAGES+1];
   stage_t           w_in;
   logic [WIDTH-1:0] w_b_eff;
   logic             w_c0;
   logic             w_stall;
   logic             r_zero;

   // Subtraction is a + ~b + 1; a borrow-in removes that +1.
   assign w_b_eff = sub ? ~b : b;
   assign w_c0    = cin ^ sub;

   // Stall depends only on the output side so in_ready never loops on in_valid.
   assign w_stall  = w_link[STAGES].ctrl.valid && !out_ready;
   assign in_ready = !w_stall;

   // Conditioned operands form the record entering stage 0.
   always_comb begin
      w_in            = '0;
      w_in.ctrl.valid = in_valid;
      w_in.ctrl.carry = w_c0;
      w_in.a_hi       = a;
      w_in.b_hi       = w_b_eff;
   end

   assign w_link[0] = w_in;

   genvar gi;
   generate
      for (gi = 0; gi < STAGES; gi++) begin : g_stage
         stage_t           w_src;
         stage_t           w_nxt;
         stage_t           r_stage;
         logic [CHUNK-1:0] w_sum;
         logic             w_cout;
         logic             w_cmsb;

         assign w_src = w_link[gi];

         rca_chunk #(
            .CHUNK (CHUNK)
         ) u_chunk (
            .a        (w_src.a_hi[CHUNK-1:0]),
            .b        (w_src.b_hi[CHUNK-1:0]),
            .cin      (w_src.ctrl.carry),
            .sum      (w_sum),
            .cout     (w_cout),
            .c_msb_in (w_cmsb)
         );

         // Insert this slice's sum, pass the carry on, drop the consumed operand bits.
         always_comb begin
            w_nxt                               = w_src;
            w_nxt.ctrl.carry                    = w_cout;
            w_nxt.ctrl.c_msb                    = w_cmsb;
            w_nxt.sum_lo[gi*CHUNK +: CHUNK]     = w_sum;
            w_nxt.a_hi                          = w_src.a_hi >> CHUNK;
            w_nxt.b_hi                          = w_src.b_hi >> CHUNK;
         end

         // Stage register: cleared on reset, frozen during a stall.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_stage <= '0;
            end else if (!w_stall) begin
               r_stage <= w_nxt;
            end
         end

         assign w_link[gi+1] = r_stage;

         if (gi == STAGES - 1) begin : g_zero
            // Zero flag is evaluated on the complete sum as it enters the output register.
            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) begin
                  r_zero <= 1'b0;
               end else if (!w_stall) begin
                  r_zero <= (w_nxt.sum_lo == '0);
               end
            end
         end
      end
   endgenerate

   assign out_valid = w_link[STAGES].ctrl.valid;
   assign sum       = w_link[STAGES].sum_lo;
   assign cout      = w_link[STAGES].ctrl.carry;
   assign ovf       = w_link[STAGES].ctrl.c_msb ^ w_link[STAGES].ctrl.carry;
   assign zero      = r_zero;

endmodule

// File: tb/tb_rca_pipe_addsub.sv
// Directed self-checking bench: 16-bit/4-stage instance for latency, flags,
// streaming, stall and reset; 4-bit/1-stage instance for the legacy vectors.
module tb_rca_pipe_addsub;

   logic        clk;
   logic        rst_n;

   logic        in_valid, in_ready, cin, sub;
   logic [15:0] a, b, sum;
   logic        out_valid, out_ready, cout, ovf, zero;

   logic        l_in_valid, l_in_ready, l_cin, l_sub;
   logic [3:0]  l_a, l_b, l_sum;
   logic        l_out_valid, l_out_ready, l_cout, l_ovf, l_zero;

   int n_checks = 0;
   int n_errors = 0;

   // Stream table, expected values worked out by hand.
   logic [15:0] sv_a   [8];
   logic [15:0] sv_b   [8];
   logic        sv_cin [8];
   logic        sv_sub [8];
   logic [15:0] sv_sum [8];
   logic        sv_cout[8];

   rca_pipe_addsub #(.WIDTH(16), .STAGES(4)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf),
      .zero      (zero)
   );

   rca_pipe_addsub #(.WIDTH(4), .STAGES(1)) u_dut_legacy (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (l_in_valid),
      .in_ready  (l_in_ready),
      .a         (l_a),
      .b         (l_b),
      .cin       (l_cin),
      .sub       (l_sub),
      .out_valid (l_out_valid),
      .out_ready (l_out_ready),
      .sum       (l_sum),
      .cout      (l_cout),
      .ovf       (l_ovf),
      .zero      (l_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic drive_vec(input int k);
      a        = sv_a[k];
      b        = sv_b[k];
      cin      = sv_cin[k];
      sub      = sv_sub[k];
      in_valid = 1'b1;
   endtask

   // Single transaction with exact-latency check; called at a falling edge.
   task automatic run_one(input string tag, input logic [15:0] va, input logic [15:0] vb,
                          input logic vcin, input logic vsub, input logic [15:0] es,
                          input logic ec, input logic eo, input logic ez);
      a = va; b = vb; cin = vcin; sub = vsub; in_valid = 1'b1;
      #1 check_eq({tag, " in_ready"}, in_ready, 1);
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         if (i == 1) in_valid = 1'b0;
         check_eq($sformatf("%s out_valid@edge%0d", tag, i), out_valid, (i == 4));
      end
      check_eq({tag, " sum"},  sum,  es);
      check_eq({tag, " cout"}, cout, ec);
      check_eq({tag, " ovf"},  ovf,  eo);
      check_eq({tag, " zero"}, zero, ez);
      $display("txn %s: a=%h b=%h cin=%b sub=%b -> sum=%h cout=%b ovf=%b zero=%b",
               tag, va, vb, vcin, vsub, sum, cout, ovf, zero);
   endtask

   initial begin
      logic [3:0] lg_a [4];
      logic [3:0] lg_b [4];
      logic       lg_cin[4];
      logic [3:0] lg_sum[4];
      logic       lg_cout[4];
      logic       lg_ovf[4];
      logic       lg_zero[4];
      int         exp_idx;

      sv_a[0]=16'h0001; sv_b[0]=16'h0002; sv_cin[0]=0; sv_sub[0]=0; sv_sum[0]=16'h0003; sv_cout[0]=0;
      sv_a[1]=16'h1111; sv_b[1]=16'h2222; sv_cin[1]=0; sv_sub[1]=0; sv_sum[1]=16'h3333; sv_cout[1]=0;
      sv_a[2]=16'hF000; sv_b[2]=16'h1000; sv_cin[2]=0; sv_sub[2]=0; sv_sum[2]=16'h0000; sv_cout[2]=1;
      sv_a[3]=16'h1000; sv_b[3]=16'h0001; sv_cin[3]=0; sv_sub[3]=1; sv_sum[3]=16'h0FFF; sv_cout[3]=1;
      sv_a[4]=16'h00FF; sv_b[4]=16'h0001; sv_cin[4]=0; sv_sub[4]=0; sv_sum[4]=16'h0100; sv_cout[4]=0;
      sv_a[5]=16'h0000; sv_b[5]=16'h0001; sv_cin[5]=0; sv_sub[5]=1; sv_sum[5]=16'hFFFF; sv_cout[5]=0;
      sv_a[6]=16'hABCD; sv_b[6]=16'h1111; sv_cin[6]=0; sv_sub[6]=0; sv_sum[6]=16'hBCDE; sv_cout[6]=0;
      sv_a[7]=16'h0F0F; sv_b[7]=16'hF0F0; sv_cin[7]=1; sv_sub[7]=0; sv_sum[7]=16'h0000; sv_cout[7]=1;

      lg_a[0]=4'd5; lg_b[0]=4'd3; lg_cin[0]=0; lg_sum[0]=4'd8;  lg_cout[0]=0; lg_ovf[0]=1; lg_zero[0]=0;
      lg_a[1]=4'd9; lg_b[1]=4'd7; lg_cin[1]=0; lg_sum[1]=4'd0;  lg_cout[1]=1; lg_ovf[1]=0; lg_zero[1]=1;
      lg_a[2]=4'd8; lg_b[2]=4'd8; lg_cin[2]=1; lg_sum[2]=4'd1;  lg_cout[2]=1; lg_ovf[2]=1; lg_zero[2]=0;
      lg_a[3]=4'd6; lg_b[3]=4'd9; lg_cin[3]=0; lg_sum[3]=4'd15; lg_cout[3]=0; lg_ovf[3]=0; lg_zero[3]=0;

      rst_n = 1'b0;
      in_valid = 0; a = 0; b = 0; cin = 0; sub = 0; out_ready = 1;
      l_in_valid = 0; l_a = 0; l_b = 0; l_cin = 0; l_sub = 0; l_out_ready = 1;

      // Reset state
      repeat (3) @(negedge clk);
      check_eq("rst out_valid", out_valid, 0);
      check_eq("rst sum",       sum,       0);
      check_eq("rst cout",      cout,      0);
      check_eq("rst ovf",       ovf,       0);
      check_eq("rst zero",      zero,      0);
      check_eq("rst in_ready",  in_ready,  1);
      check_eq("rst legacy out_valid", l_out_valid, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed single transactions
      run_one("add_basic",  16'h1234, 16'h4321, 0, 0, 16'h5555, 0, 0, 0);
      run_one("add_ffff_1", 16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0, 1);
      run_one("add_7fff_1", 16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1, 0);
      run_one("sub_5_7",    16'h0005, 16'h0007, 0, 1, 16'hFFFE, 0, 0, 0);
      run_one("sub_8000_1", 16'h8000, 16'h0001, 0, 1, 16'h7FFF, 1, 1, 0);
      run_one("sub_9_4_b1", 16'h0009, 16'h0004, 1, 1, 16'h0004, 1, 0, 0);

      // Back-to-back stream of 8
      for (int t = 0; t <= 12; t++) begin
         if (t > 0) begin
            @(negedge clk);
            exp_idx = (t >= 4 && t <= 11) ? t - 4 : -1;
            check_eq($sformatf("stream out_valid t%0d", t), out_valid, (exp_idx >= 0));
            check_eq($sformatf("stream in_ready t%0d", t), in_ready, 1);
            if (exp_idx >= 0) begin
               check_eq($sformatf("stream sum #%0d", exp_idx),  sum,  sv_sum[exp_idx]);
               check_eq($sformatf("stream cout #%0d", exp_idx), cout, sv_cout[exp_idx]);
               $display("txn stream #%0d: sum=%h cout=%b", exp_idx, sum, cout);
            end
         end
         if (t < 8) drive_vec(t);
         else       in_valid = 1'b0;
      end
      repeat (2) @(negedge clk);

      // Stall with a full pipe for three cycles; held input accepted on release
      for (int t = 0; t <= 11; t++) begin
         if (t > 0) begin
            @(negedge clk);
            case (t)
               4, 5, 6: exp_idx = 0;
               7:       exp_idx = 1;
               8:       exp_idx = 2;
               9:       exp_idx = 3;
               10:      exp_idx = 4;
               default: exp_idx = -1;
            endcase
            check_eq($sformatf("stall out_valid t%0d", t), out_valid, (exp_idx >= 0));
            check_eq($sformatf("stall in_ready t%0d", t), in_ready, !(t >= 4 && t <= 6));
            if (exp_idx >= 0) begin
               check_eq($sformatf("stall sum t%0d", t),  sum,  sv_sum[exp_idx]);
               check_eq($sformatf("stall cout t%0d", t), cout, sv_cout[exp_idx]);
               $display("txn stall t%0d: sum=%h cout=%b", t, sum, cout);
            end
         end
         if (t <= 3) begin
            drive_vec(t);
            out_ready = (t != 3);
         end else if (t <= 6) begin
            drive_vec(4);
            out_ready = (t == 6);
         end else begin
            in_valid  = 1'b0;
            out_ready = 1'b1;
         end
         if (t == 6) #1 check_eq("stall release in_ready", in_ready, 1);
      end

      // Reset with three results still in flight
      for (int t = 0; t <= 3; t++) begin
         drive_vec(t);
         @(negedge clk);
      end
      in_valid = 1'b0;
      check_eq("rst_mid out_valid before", out_valid, 1);
      check_eq("rst_mid sum before", sum, sv_sum[0]);
      rst_n = 1'b0;
      #1;
      check_eq("rst_mid out_valid async", out_valid, 0);
      check_eq("rst_mid sum async", sum, 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int t = 0; t < 6; t++) begin
         @(negedge clk);
         check_eq($sformatf("rst_mid idle out_valid t%0d", t), out_valid, 0);
      end
      run_one("post_rst", 16'h1234, 16'h4321, 0, 0, 16'h5555, 0, 0, 0);

      // Legacy 4-bit single-stage vectors
      for (int k = 0; k < 4; k++) begin
         l_a = lg_a[k]; l_b = lg_b[k]; l_cin = lg_cin[k]; l_sub = 1'b0; l_in_valid = 1'b1;
         @(negedge clk);
         check_eq($sformatf("legacy out_valid #%0d", k), l_out_valid, 1);
         check_eq($sformatf("legacy sum #%0d", k),  l_sum,  lg_sum[k]);
         check_eq($sformatf("legacy cout #%0d", k), l_cout, lg_cout[k]);
         check_eq($sformatf("legacy ovf #%0d", k),  l_ovf,  lg_ovf[k]);
         check_eq($sformatf("legacy zero #%0d", k), l_zero, lg_zero[k]);
         $display("txn legacy #%0d: %0d+%0d+%0d -> sum=%0d cout=%b", k, lg_a[k], lg_b[k], lg_cin[k], l_sum, l_cout);
      end
      l_in_valid = 1'b0;
      @(negedge clk);
      check_eq("legacy drain out_valid", l_out_valid, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
